// File: rtl/axis_packet_bridge.sv
// axis_packet_bridge: DMA <-> compute-core bridge.
// Parses a length-header packet from the DMA input stream and forwards the
// payload to the core. Results announced by the core are buffered in a small
// FIFO and returned to the DMA as a single TLAST-terminated packet.
// Length mismatches, stray results and overlapping announcements are
// reported through a sticky error flag.
module axis_packet_bridge #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_W-1:0]     S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]   S_AXIS_TKEEP,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_W-1:0]     M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_W-1:0]     core_x,
  output logic                  core_x_valid,
  input  logic                  core_x_ready,
  input  logic [DATA_W-1:0]     core_y,
  input  logic                  core_y_valid,
  output logic                  core_y_ready,
  input  logic [CNT_W-1:0]      core_ycount,
  input  logic                  core_ycount_valid,
  output logic                  status_busy,
  output logic                  status_err,
  input  logic                  err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  in_rem_q, in_rem_d;
  logic              skip_first_q, skip_first_d;
  logic [CNT_W-1:0]  out_rem_q, out_rem_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;

  logic              armed;
  logic              fifo_empty;
  logic              fifo_full;
  logic              out_idle;
  logic              s_ready;
  logic              rx;
  logic              tx;
  logic              push;
  logic              pop;
  logic              in_err;
  logic              arm_err;
  logic              drop_err;
  logic [CNT_W-1:0]  hdr_val;
  logic              unused_tkeep;

  // Input byte enables carry no information for this protocol.
  assign unused_tkeep = ^S_AXIS_TKEEP;

  assign hdr_val    = S_AXIS_TDATA[CNT_W-1:0];
  assign armed      = (out_rem_q != '0);
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OW'(FIFO_DEPTH));
  // A new header is only taken once the previous result packet has fully left.
  assign out_idle   = !armed && fifo_empty;

  // Input-side ready depends on which part of the packet is being consumed.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      ST_HDR:  s_ready = out_idle;
      ST_PAY:  s_ready = core_x_ready;
      ST_SKIP: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // Ready is forced low while reset is asserted so nothing is acknowledged.
  assign S_AXIS_TREADY = AXIS_ARESETN & s_ready;
  assign rx            = S_AXIS_TVALID & S_AXIS_TREADY;

  // Payload is a zero-latency pass-through to the core.
  assign core_x_valid = (state_q == ST_PAY) & S_AXIS_TVALID;
  assign core_x       = (state_q == ST_PAY) ? S_AXIS_TDATA : '0;

  // Input packet parser: header, payload forwarding, over-length draining.
  always_comb begin
    state_d      = state_q;
    in_rem_d     = in_rem_q;
    skip_first_d = skip_first_q;
    in_err       = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        if (rx) begin
          if (S_AXIS_TLAST) begin
            in_err = 1'b1;
          end else if (hdr_val != '0) begin
            in_rem_d = hdr_val;
            state_d  = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (rx) begin
          if (in_rem_q != '0) begin
            in_rem_d = in_rem_q - CNT_W'(1);
          end
          if (in_rem_q <= CNT_W'(1)) begin
            if (S_AXIS_TLAST) begin
              state_d = ST_HDR;
            end else begin
              state_d      = ST_SKIP;
              skip_first_d = 1'b1;
            end
          end else if (S_AXIS_TLAST) begin
            in_err  = 1'b1;
            state_d = ST_HDR;
          end
        end
      end
      ST_SKIP: begin
        if (rx) begin
          if (skip_first_q) begin
            in_err = 1'b1;
          end
          skip_first_d = 1'b0;
          if (S_AXIS_TLAST) begin
            state_d = ST_HDR;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Output arming from the core's result-count announcement.
  always_comb begin
    out_rem_d = out_rem_q;
    arm_err   = 1'b0;
    if (!armed) begin
      if (core_ycount_valid && (core_ycount != '0)) begin
        out_rem_d = core_ycount;
      end
    end else begin
      if (core_ycount_valid) begin
        arm_err = 1'b1;
      end
      if (tx) begin
        out_rem_d = out_rem_q - CNT_W'(1);
      end
    end
  end

  // Results are only buffered while a packet is armed; otherwise they are
  // swallowed and flagged so the core never stalls on an unexpected result.
  assign core_y_ready = AXIS_ARESETN & (armed ? !fifo_full : 1'b1);
  assign push         = armed & core_y_valid & !fifo_full;
  assign drop_err     = !armed & core_y_valid;

  assign M_AXIS_TVALID = !fifo_empty;
  assign tx            = M_AXIS_TVALID & M_AXIS_TREADY;
  assign pop           = tx;

  assign M_AXIS_TDATA = M_AXIS_TVALID ? mem_q[rd_ptr_q] : '0;
  assign M_AXIS_TKEEP = M_AXIS_TVALID ? '1 : '0;
  assign M_AXIS_TLAST = M_AXIS_TVALID & (out_rem_q == CNT_W'(1));

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    occ_d    = occ_q + OW'(push) - OW'(pop);
  end

  // Sticky error: a new error in the same cycle as a clear takes priority.
  always_comb begin
    err_d = err_q;
    if (in_err || arm_err || drop_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  assign status_busy = (state_q != ST_HDR) | armed | !fifo_empty;
  assign status_err  = err_q;

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q      <= ST_HDR;
      in_rem_q     <= '0;
      skip_first_q <= 1'b0;
      out_rem_q    <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_rem_q     <= in_rem_d;
      skip_first_q <= skip_first_d;
      out_rem_q    <= out_rem_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

  // Result storage; contents are qualified by occupancy, so no reset needed.
  always_ff @(posedge AXIS_ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= core_y;
    end
  end

endmodule

// File: tb/tb_axis_packet_bridge.sv
// Scoreboard bench for axis_packet_bridge: directed scenarios plus a
// randomised packet loop checked against a packet-level reference model.
module tb_axis_packet_bridge;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata;
  logic [1:0]    s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic [1:0]    m_tkeep;
  logic          m_tlast, m_tvalid, m_tready;
  logic [DW-1:0] core_x;
  logic          core_x_valid, core_x_ready;
  logic [DW-1:0] core_y;
  logic          core_y_valid, core_y_ready;
  logic [CW-1:0] core_ycount;
  logic          core_ycount_valid;
  logic          status_busy, status_err, err_clr;

  axis_packet_bridge #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(FD)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .core_x(core_x), .core_x_valid(core_x_valid), .core_x_ready(core_x_ready),
    .core_y(core_y), .core_y_valid(core_y_valid), .core_y_ready(core_y_ready),
    .core_ycount(core_ycount), .core_ycount_valid(core_ycount_valid),
    .status_busy(status_busy), .status_err(status_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_x[$];
  logic [DW-1:0] exp_od[$];
  logic          exp_ol[$];
  logic          exp_err = 1'b0;
  logic          cx_rand = 1'b0, cx_fixed = 1'b1;
  logic          rdy_rand = 1'b0, rdy_fixed = 1'b1;
  logic          res_gaps = 1'b0;
  logic [DW-1:0] in_beats[$];
  logic [DW-1:0] res_vals[$];
  int            res_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (at %0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Background ready generators (fixed level or random per cycle).
  initial begin
    core_x_ready = 1'b1;
    m_tready     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      core_x_ready = cx_rand ? 1'($urandom_range(0, 1)) : cx_fixed;
      m_tready     = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake.
  initial begin
    logic [DW-1:0] ed;
    logic          el;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_x_valid && core_x_ready) begin
          if (exp_x.size() == 0) fail_now("core_x_unexpected");
          else begin
            ed = exp_x.pop_front();
            chk("core_x", core_x, ed);
          end
        end
        if (m_tvalid && m_tready) begin
          if (exp_od.size() == 0) fail_now("m_axis_unexpected");
          else begin
            ed = exp_od.pop_front();
            el = exp_ol.pop_front();
            chk("m_tdata", m_tdata, ed);
            chk("m_tlast", m_tlast, el);
            chk("m_tkeep", m_tkeep, 2'b11);
          end
        end
        if (!m_tvalid) chk("m_idle_zero", {m_tdata, m_tkeep, m_tlast}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sends in_beats (TLAST on the final one); beats from skip_from on must be drained.
  task automatic send_in(input int skip_from);
    int w;
    for (int i = 0; i < in_beats.size(); i++) begin
      s_tdata  = in_beats[i];
      s_tlast  = (i == in_beats.size() - 1);
      s_tkeep  = 2'($urandom_range(0, 3));
      s_tvalid = 1'b1;
      @(negedge clk);
      if (i >= skip_from) begin
        chk("skip_s_tready", s_tready, 1);
        chk("skip_core_x_valid", core_x_valid, 0);
      end
      w = 0;
      while (!s_tready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!s_tready) begin
        fail_now("s_axis_timeout");
        break;
      end
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic announce(input logic [CW-1:0] c);
    core_ycount       = c;
    core_ycount_valid = 1'b1;
    tick();
    core_ycount_valid = 1'b0;
  endtask

  // Offers res_vals to the bridge; TLAST expected on entry c-1.
  task automatic send_res(input int c);
    int w;
    res_acc = 0;
    for (int i = 0; i < res_vals.size(); i++) begin
      if (res_gaps && $urandom_range(0, 2) == 0) tick();
      core_y       = res_vals[i];
      core_y_valid = 1'b1;
      exp_od.push_back(res_vals[i]);
      exp_ol.push_back(i == c - 1);
      @(negedge clk);
      w = 0;
      while (!core_y_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!core_y_ready) begin
        fail_now("core_y_timeout");
        break;
      end
      tick();
      res_acc++;
      core_y_valid = 1'b0;
    end
    core_y_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((exp_x.size() != 0 || exp_od.size() != 0 || m_tvalid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) fail_now(name);
    tick();
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic run_t1();
    in_beats = {16'h0003, 16'h000A, 16'h0014, 16'h001E};
    exp_x.push_back(16'h000A); exp_x.push_back(16'h0014); exp_x.push_back(16'h001E);
    send_in(99);
    announce(16'd2);
    res_vals = {16'h001E, 16'h0032};
    send_res(2);
    wait_drain("t1_drain");
    chk("t1_err", status_err, exp_err);
    chk("t1_busy", status_busy, 0);
  endtask

  initial begin
    int w;
    int n, l, kind, c, hidx, skip_from;
    logic [DW-1:0] v;
    s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tvalid = 0;
    core_y = '0; core_y_valid = 0; core_ycount = '0; core_ycount_valid = 0; err_clr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_core_y_ready", core_y_ready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", status_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_tready", s_tready, 1);
    chk("idle_core_y_ready", core_y_ready, 1);
    chk("idle_err", status_err, 0);
    tick();

    // 1: basic packet
    run_t1();

    // 2: FIFO back-pressure, 6 results through a 4-deep FIFO
    rdy_fixed = 1'b0; tick(); tick();
    announce(16'd6);
    res_vals = {};
    for (int i = 0; i < 6; i++) res_vals.push_back(DW'($urandom));
    fork
      send_res(6);
      begin
        repeat (12) @(negedge clk);
        chk("t2_accepted", res_acc, 4);
        chk("t2_core_y_ready", core_y_ready, 0);
        chk("t2_hold_data", m_tdata, res_vals[0]);
        chk("t2_hold_last", m_tlast, 0);
        rdy_fixed = 1'b1;
      end
    join
    wait_drain("t2_drain");
    chk("t2_err", status_err, 0);

    // 3: short packet, then a good one, error sticky until cleared
    in_beats = {16'h0004, 16'h1111, 16'h2222};
    exp_x.push_back(16'h1111); exp_x.push_back(16'h2222);
    exp_err = 1'b1;
    send_in(99);
    chk("t3_err", status_err, 1);
    chk("t3_in_hdr", status_busy, 0);
    run_t1();
    do_clr();
    chk("t3_cleared", status_err, 0);

    // 4: over-length packet drained
    in_beats = {16'h0002, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    exp_x.push_back(16'hA001); exp_x.push_back(16'hA002);
    exp_err = 1'b1;
    send_in(3);
    wait_drain("t4_drain");
    chk("t4_err", status_err, 1);
    do_clr();

    // 5: header held off while the output drains
    rdy_fixed = 1'b0; tick(); tick();
    announce(16'd2);
    res_vals = {16'hBEE0, 16'hBEE1};
    send_res(2);
    s_tdata = 16'h0001; s_tlast = 1'b0; s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_blocked", s_tready, 0);
    end
    rdy_fixed = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_tready && w < 20);
    if (!m_tready) fail_now("t5_tready_release");
    chk("t5_first_tx_blocked", s_tready, 0);
    @(negedge clk);
    chk("t5_tlast_blocked", s_tready, 0);
    chk("t5_tlast", m_tlast, 1);
    @(negedge clk);
    chk("t5_open", s_tready, 1);
    tick();
    s_tdata = 16'h5A5A; s_tlast = 1'b1;
    exp_x.push_back(16'h5A5A);
    @(negedge clk);
    chk("t5_payload_ready", s_tready, 1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_drain("t5_drain");
    chk("t5_busy", status_busy, 0);

    // 6: asynchronous reset mid-payload with 3 results buffered
    rdy_fixed = 1'b0; cx_fixed = 1'b0; tick(); tick();
    s_tdata = 16'h0005; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge clk);
    chk("t6_hdr_ready", s_tready, 1);
    tick();
    s_tdata = 16'h7777;
    announce(16'd4);
    res_vals = {16'hC001, 16'hC002, 16'hC003};
    send_res(4);
    @(negedge clk);
    chk("t6_pre_core_x_valid", core_x_valid, 1);
    chk("t6_pre_m_tvalid", m_tvalid, 1);
    chk("t6_pre_core_y_ready", core_y_ready, 1);
    chk("t6_pre_busy", status_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_s_tready", s_tready, 0);
    chk("t6_core_x_valid", core_x_valid, 0);
    chk("t6_core_y_ready", core_y_ready, 0);
    chk("t6_busy", status_busy, 0);
    s_tvalid = 1'b0;
    exp_od.delete(); exp_ol.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cx_fixed = 1'b1; rdy_fixed = 1'b1;
    tick(); tick();
    run_t1();

    // 7: remaining error sources and edge cases
    core_y = 16'hDEAD; core_y_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    chk("t7_unarmed_ready", core_y_ready, 1);
    tick();
    core_y_valid = 1'b0; err_clr = 1'b0;
    exp_err = 1'b1;
    chk("t7_set_wins", status_err, 1);
    chk("t7_no_output", m_tvalid, 0);
    do_clr();
    announce(16'd0);
    chk("t7_zero_count_busy", status_busy, 0);
    chk("t7_zero_count_err", status_err, 0);
    announce(16'd1);
    announce(16'd3);
    exp_err = 1'b1;
    res_vals = {16'h0F0F};
    send_res(1);
    wait_drain("t7_double_drain");
    chk("t7_double_err", status_err, 1);
    do_clr();
    in_beats = {16'h0007};
    exp_err = 1'b1;
    send_in(99);
    chk("t7_hdr_only_err", status_err, 1);
    do_clr();
    in_beats = {16'h0000, 16'h0002, 16'h1234, 16'h5678};
    exp_x.push_back(16'h1234); exp_x.push_back(16'h5678);
    send_in(99);
    wait_drain("t7_zero_hdr_drain");
    chk("t7_zero_hdr_err", status_err, 0);

    // 8: randomised packets against the packet-level model
    cx_rand = 1'b1; rdy_rand = 1'b1; res_gaps = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 6);
      kind = $urandom_range(0, 5);
      if (kind == 0) l = 0;
      else if (kind == 1) l = (n > 1) ? n - 1 : n;
      else if (kind == 2) l = n + $urandom_range(1, 3);
      else l = n;
      in_beats = {};
      hidx = 0;
      if ($urandom_range(0, 3) == 0) begin
        in_beats.push_back(16'h0000);
        hidx = 1;
      end
      in_beats.push_back(DW'(n));
      for (int i = 0; i < l; i++) begin
        v = DW'($urandom);
        in_beats.push_back(v);
        if (i < n) exp_x.push_back(v);
      end
      if (l != n) exp_err = 1'b1;
      skip_from = (l > n) ? hidx + 1 + n : 999;
      send_in(skip_from);
      c = $urandom_range(1, 7);
      announce(CW'(c));
      res_vals = {};
      for (int i = 0; i < c; i++) res_vals.push_back(DW'($urandom));
      send_res(c);
      wait_drain("rand_drain");
      chk("rand_err", status_err, exp_err);
      chk("rand_busy", status_busy, 0);
      if ($urandom_range(0, 1) == 1) do_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_packet_bridge.md
Name: axis_packet_bridge

Overview:
Parametrised next-generation bridge between the DMA AXI-Stream channels and a compute core.
- Parses a length-header packet from the DMA and forwards the payload to the core over a valid/ready port.
- Buffers core results in a FIFO of configurable depth.
- Returns the results to the DMA as one TLAST-terminated packet whose length the core announces.
- Adds packet-length error detection, over-length packet draining, and one-packet-at-a-time serialisation.

Parameters:
DATA_W, 16, stream and core data width; a multiple of 8.
CNT_W, 16, width of the header and result-count fields; CNT_W <= DATA_W.
FIFO_DEPTH, 4, result FIFO entries; a power of two, >= 2.

Ports:
AXIS_ACLK  in  1  single clock for both streams and the core
AXIS_ARESETN  in  1  asynchronous, active-low reset
S_AXIS_TDATA  in  DATA_W  input stream data
S_AXIS_TKEEP  in  DATA_W/8  ignored
S_AXIS_TLAST  in  1  input packet boundary
S_AXIS_TVALID  in  1  input beat valid
S_AXIS_TREADY  out  1  input beat accepted
M_AXIS_TDATA  out  DATA_W  output data; 0 when TVALID=0
M_AXIS_TKEEP  out  DATA_W/8  all ones when TVALID=1, else 0
M_AXIS_TLAST  out  1  final beat of the output packet
M_AXIS_TVALID  out  1  output beat valid
M_AXIS_TREADY  in  1  downstream ready
core_x  out  DATA_W  payload word to the core
core_x_valid  out  1  payload valid
core_x_ready  in  1  core accepts the payload word
core_y  in  DATA_W  core result
core_y_valid  in  1  result valid
core_y_ready  out  1  bridge accepts the result
core_ycount  in  CNT_W  number of results for the current packet
core_ycount_valid  in  1  core_ycount valid, single-cycle pulse
status_busy  out  1  packet in flight
status_err  out  1  sticky error flag
err_clr  in  1  clears status_err

Behaviour:
- Reset: AXIS_ARESETN low asynchronously clears all state, counters and FIFO pointers. While it is low, every output is 0, including S_AXIS_TREADY.
- Handshakes: RX = S_AXIS_TVALID & S_AXIS_TREADY; TX = M_AXIS_TVALID & M_AXIS_TREADY.
- Input FSM, states HDR / PAY / SKIP; in_rem is a CNT_W-bit counter.
  - HDR: S_AXIS_TREADY = out_idle, where out_idle = (out_rem == 0) & FIFO empty & no output armed.
    - RX with TLAST=1: header-only packet; set err, stay HDR.
    - RX with TDATA[CNT_W-1:0] == 0: ignore, stay HDR.
    - Otherwise: in_rem <= header value, go to PAY.
  - PAY: zero-latency pass-through. core_x = S_AXIS_TDATA, core_x_valid = S_AXIS_TVALID, S_AXIS_TREADY = core_x_ready. Each RX decrements in_rem.
    - TLAST with in_rem > 1: short packet; set err, go to HDR.
    - in_rem == 1 with TLAST: go to HDR.
    - in_rem == 1 without TLAST: go to SKIP.
  - SKIP: S_AXIS_TREADY = 1, core_x_valid = 0, beats are discarded. The first discarded beat sets err. RX with TLAST goes to HDR.
- Output arming:
  - When no output is armed (out_rem == 0) and core_ycount_valid with a nonzero count arrives: out_rem <= core_ycount, output is armed.
  - core_ycount_valid while already armed is ignored and sets err.
  - core_ycount_valid with a zero count is ignored.
- Result FIFO:
  - While armed: core_y_ready = !full; a result is pushed when core_y_valid & core_y_ready.
  - While not armed: core_y_ready = 1, results are dropped, and any core_y_valid sets err.
  - No pop-to-push bypass when full. Reads come from the FIFO head, with no added latency once an entry is written.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- Output stream:
  - M_AXIS_TVALID = FIFO not empty; M_AXIS_TDATA = head entry.
  - M_AXIS_TLAST = M_AXIS_TVALID & (out_rem == 1).
  - Each TX pops one entry and decrements out_rem. The TX with TLAST disarms the output.
  - TDATA, TLAST and TKEEP are held stable while TVALID=1 and TREADY=0.
- Status:
  - status_busy = (state != HDR) | armed | FIFO not empty.
  - status_err is sticky. err_clr clears it; a set condition in the same cycle as err_clr wins.
- Arithmetic: counters are unsigned CNT_W bits and are never decremented below 0.

Test Plan:
1. DATA_W=16. Input 0x0003, 0x000A, 0x0014, 0x001E (TLAST on the last beat); core returns count 2 with results 0x001E, 0x0032 -> core_x sees 0x000A, 0x0014, 0x001E; output is 0x001E, then 0x0032 with TLAST; TKEEP=2'b11; err=0.
2. FIFO_DEPTH=4, M_AXIS_TREADY=0, core offers 6 results (count 6) -> core_y_ready falls after 4 pushes; releasing TREADY yields all 6 results in order with TLAST only on the 6th.
3. Header 0x0004 then 2 payload beats, the second with TLAST -> err=1, FSM in HDR; a following correct packet processes normally; err stays 1 until err_clr.
4. Header 0x0002 then 4 beats, TLAST on the 4th -> only beats 1-2 reach the core, err=1, S_AXIS_TREADY=1 during SKIP.
5. New header presented while the output is still draining -> S_AXIS_TREADY=0 until the TLAST TX; the header is accepted in the cycle after.
6. AXIS_ARESETN pulled low mid-PAY with the FIFO holding 3 entries -> M_AXIS_TVALID, TREADY and core_x_valid drop to 0 immediately; after release, a fresh packet from test 1 passes correctly.
